// File: rtl/uart_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_frac
//
// Programmable fractional-N baud generator. Divides clk into an oversample
// tick (os_tick), an end-of-bit tick (bit_tick) and a mid-bit sample tick
// (mid_tick). The divisor can be rewritten at run time; while running, a new
// divisor is parked in a shadow register and takes over at the next period
// boundary so no period is ever shortened or merged. resync re-phases the
// generator to a receiver start-bit edge.
//
// Optional feature macro: UART_BAUD_FRAC_EN
//   defined   : fractional accumulator present, period is div_int or div_int+1
//   undefined : accumulator removed, cfg_frac ignored, period is div_int
//
// Ports
//   clk       in   system clock (single domain)
//   rst       in   synchronous active-high reset
//   baud_en   in   run enable; low freezes all counters and silences ticks
//   cfg_we    in   single-cycle divisor write strobe
//   cfg_int   in   integer divisor, clocks per oversample tick (>= 2)
//   cfg_frac  in   fractional divisor, 1/2^FRAC_W clock units
//   resync    in   one-cycle pulse, restarts the bit phase
//   os_tick   out  oversample tick, one-cycle pulse
//   bit_tick  out  end-of-bit pulse, coincides with os_tick
//   mid_tick  out  mid-bit sample pulse, coincides with os_tick
//   cfg_err   out  one-cycle pulse after a rejected cfg_we
// ---------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int SYS_CLK = 50000000,
    parameter int BAUD    = 9600,
    parameter int OVS     = 16,
    parameter int DIV_W   = 16,
    parameter int FRAC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_en,
    input  logic              cfg_we,
    input  logic [DIV_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              resync,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              cfg_err
);

    localparam longint           DIV_DEN  = longint'(BAUD) * longint'(OVS);
    localparam logic [DIV_W-1:0] DEF_INT  = DIV_W'(longint'(SYS_CLK) / DIV_DEN);
    localparam logic [DIV_W-1:0] MIN_INT  = DIV_W'(2);
    localparam int               PH_W     = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [DIV_W:0]   CNT_ZERO = {(DIV_W+1){1'b0}};
    localparam logic [DIV_W:0]   CNT_ONE  = (DIV_W+1)'(1);

    logic [DIV_W-1:0] div_int_r, sh_int_r, div_int_s, sh_int_s;
    logic             sh_pend_r, sh_pend_s;
    logic [DIV_W:0]   cnt_r, cnt_s, period_last_s;
    logic [PH_W-1:0]  ph_r, ph_s;
    logic             cfg_ok_s, period_end_s;
    logic             os_tick_s, bit_tick_s, mid_tick_s, cfg_err_s;

`ifdef UART_BAUD_FRAC_EN
    localparam longint            FRAC_ONE  = longint'(1) << FRAC_W;
    localparam logic [FRAC_W-1:0] DEF_FRAC  =
        FRAC_W'((longint'(SYS_CLK) * FRAC_ONE / DIV_DEN) % FRAC_ONE);
    localparam logic [FRAC_W-1:0] FRAC_ZERO = {FRAC_W{1'b0}};

    logic [FRAC_W-1:0] div_frac_r, sh_frac_r, acc_r;
    logic [FRAC_W-1:0] div_frac_s, sh_frac_s, acc_s, frac_step_s;
    logic              carry_r, carry_s;
`else
    logic unused_cfg_frac_s;
    assign unused_cfg_frac_s = ^cfg_frac;
`endif

    // Period end detection; resync wins over a coincident period end.
    always_comb begin
`ifdef UART_BAUD_FRAC_EN
        period_last_s = {1'b0, div_int_r} + {{DIV_W{1'b0}}, carry_r} - CNT_ONE;
`else
        period_last_s = {1'b0, div_int_r} - CNT_ONE;
`endif
        cfg_ok_s = (cfg_int >= MIN_INT);
        // '>=' rather than '==' so a count held above a newly loaded shorter
        // divisor still terminates its period on resume.
        period_end_s = baud_en && !resync && (cnt_r >= period_last_s);
    end

    // Next-state logic for counters, divisor registers and tick outputs.
    always_comb begin
        cnt_s       = cnt_r;
        ph_s        = ph_r;
        div_int_s   = div_int_r;
        sh_int_s    = sh_int_r;
        sh_pend_s   = sh_pend_r;
`ifdef UART_BAUD_FRAC_EN
        acc_s       = acc_r;
        carry_s     = carry_r;
        div_frac_s  = div_frac_r;
        sh_frac_s   = sh_frac_r;
        // At a swapping boundary the incoming fraction already sets the
        // carry of the first new period.
        frac_step_s = sh_pend_r ? sh_frac_r : div_frac_r;
`endif

        if (resync) begin
            cnt_s = CNT_ZERO;
            ph_s  = PH_ZERO;
`ifdef UART_BAUD_FRAC_EN
            acc_s   = FRAC_ZERO;
            carry_s = 1'b0;
`endif
            if (sh_pend_r) begin
                div_int_s = sh_int_r;
`ifdef UART_BAUD_FRAC_EN
                div_frac_s = sh_frac_r;
`endif
                sh_pend_s = 1'b0;
            end else begin
                sh_pend_s = sh_pend_r;
            end
        end else if (period_end_s) begin
            cnt_s = CNT_ZERO;
            ph_s  = (ph_r == PH_LAST) ? PH_ZERO : (ph_r + PH_ONE);
`ifdef UART_BAUD_FRAC_EN
            {carry_s, acc_s} = {1'b0, acc_r} + {1'b0, frac_step_s};
`endif
            if (sh_pend_r) begin
                div_int_s = sh_int_r;
`ifdef UART_BAUD_FRAC_EN
                div_frac_s = sh_frac_r;
`endif
                sh_pend_s = 1'b0;
            end else begin
                sh_pend_s = sh_pend_r;
            end
        end else if (baud_en) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end

        // A write lands after any boundary copy so the newest value wins.
        if (cfg_we && cfg_ok_s) begin
            sh_int_s = cfg_int;
`ifdef UART_BAUD_FRAC_EN
            sh_frac_s = cfg_frac;
`endif
            if (baud_en) begin
                sh_pend_s = 1'b1;
            end else begin
                // Stopped: load directly and drop any stale pending value.
                div_int_s = cfg_int;
`ifdef UART_BAUD_FRAC_EN
                div_frac_s = cfg_frac;
`endif
                sh_pend_s = 1'b0;
            end
        end else begin
            sh_int_s = sh_int_s;
        end

        os_tick_s  = period_end_s;
        bit_tick_s = period_end_s && (ph_r == PH_LAST);
        mid_tick_s = period_end_s && (ph_r == PH_MID);
        cfg_err_s  = cfg_we && !cfg_ok_s;
    end

    // State and output registers with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_int_r <= DEF_INT;
            sh_int_r  <= DEF_INT;
            sh_pend_r <= 1'b0;
            cnt_r     <= CNT_ZERO;
            ph_r      <= PH_ZERO;
`ifdef UART_BAUD_FRAC_EN
            div_frac_r <= DEF_FRAC;
            sh_frac_r  <= DEF_FRAC;
            acc_r      <= FRAC_ZERO;
            carry_r    <= 1'b0;
`endif
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            div_int_r <= div_int_s;
            sh_int_r  <= sh_int_s;
            sh_pend_r <= sh_pend_s;
            cnt_r     <= cnt_s;
            ph_r      <= ph_s;
`ifdef UART_BAUD_FRAC_EN
            div_frac_r <= div_frac_s;
            sh_frac_r  <= sh_frac_s;
            acc_r      <= acc_s;
            carry_r    <= carry_s;
`endif
            os_tick  <= os_tick_s;
            bit_tick <= bit_tick_s;
            mid_tick <= mid_tick_s;
            cfg_err  <= cfg_err_s;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen_frac
//
// Scoreboard bench for uart_baud_gen_frac. The stimulus process pushes the
// expected spacing (in clocks) and bit/mid flags of each upcoming os_tick
// into a queue; an independent monitor pops one entry per observed os_tick.
// Expected gaps are hand-derived for the 50 MHz / 9600 / x16 defaults
// (325.5 clocks per oversample tick) and for the directed divisor writes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst, baud_en, cfg_we, resync;
    logic [15:0] cfg_int;
    logic [3:0]  cfg_frac;
    logic        os_tick, bit_tick, mid_tick, cfg_err;

    always #5 clk = ~clk;

    uart_baud_gen_frac dut (
        .clk      (clk),
        .rst      (rst),
        .baud_en  (baud_en),
        .cfg_we   (cfg_we),
        .cfg_int  (cfg_int),
        .cfg_frac (cfg_frac),
        .resync   (resync),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .cfg_err  (cfg_err)
    );

    typedef struct {
        int gap;
        bit bt;
        bit mt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   last_ref = 0;
    bit   bit_chk_en = 1'b0;
    int   last_bit = 0;
    int   bit_lo   = 0;
    int   bit_hi   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one scoreboard entry per os_tick, gap measured in clock edges.
    always @(negedge clk) begin
        if (os_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_os_tick", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("os_gap", 64'(cyc - last_ref), 64'(mon_e.gap));
                check("tick_flags", {62'd0, bit_tick, mid_tick}, {62'd0, mon_e.bt, mon_e.mt});
            end
            last_ref = cyc;
            if (bit_tick === 1'b1 && bit_chk_en) begin
                n_cmp++;
                if ((cyc - last_bit) < bit_lo || (cyc - last_bit) > bit_hi) begin
                    n_bad++;
                    $display("FAIL bit_spacing: got %0d, expected %0d..%0d", cyc - last_bit, bit_lo, bit_hi);
                end
                last_bit = cyc;
            end
        end else if (bit_tick !== 1'b0 || mid_tick !== 1'b0) begin
            check("orphan_tick", {62'd0, bit_tick, mid_tick}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic push(input int gap, input int idx);
        exp_t e;
        e.gap = gap;
        e.bt  = (idx % 16 == 0);
        e.mt  = (idx % 16 == 8);
        exp_q.push_back(e);
    endtask

    initial begin
        int e0;
        int r;
        int quiet;
        int gap;
`ifdef UART_BAUD_FRAC_EN
        int tbl_b[7] = '{4, 4, 5, 4, 5, 4, 5};
`else
        int tbl_b[7] = '{4, 4, 4, 4, 4, 4, 4};
`endif
        rst = 1'b1; baud_en = 1'b0; cfg_we = 1'b0; resync = 1'b0;
        cfg_int = 16'd0; cfg_frac = 4'd0;
        step(); step(); step();
        check("reset_outputs", {60'd0, os_tick, bit_tick, mid_tick, cfg_err}, 64'd0);

        // Default divisor 325.5, free running.
        rst = 1'b0; baud_en = 1'b1;
        last_ref = cyc; last_bit = cyc; bit_chk_en = 1'b1;
`ifdef UART_BAUD_FRAC_EN
        bit_lo = 5207; bit_hi = 5209;
`else
        bit_lo = 5200; bit_hi = 5200;
`endif
        for (int i = 1; i <= 120; i++) begin
`ifdef UART_BAUD_FRAC_EN
            gap = 325 + (((i >= 3) && (i % 2 == 1)) ? 1 : 0);
`else
            gap = 325;
`endif
            push(gap, i);
        end
        drain(45000);
        bit_chk_en = 1'b0;
        baud_en = 1'b0;

        // Direct load while stopped, then a shadow write mid-period.
        rst = 1'b1; step(); rst = 1'b0;
        cfg_int = 16'd4; cfg_frac = 4'd8; cfg_we = 1'b1; step(); cfg_we = 1'b0;
        check("no_err_on_valid", {63'd0, cfg_err}, 64'd0);
        e0 = cyc; baud_en = 1'b1; last_ref = e0;
        for (int i = 0; i < 7; i++) push(tbl_b[i], i + 1);
        for (int i = 8; i <= 20; i++) push(10, i);
        wait_until(e0 + 26);
        cfg_int = 16'd10; cfg_frac = 4'd0; cfg_we = 1'b1; step(); cfg_we = 1'b0;
        wait_until(e0 + 60);
        cfg_int = 16'd1; cfg_we = 1'b1; step(); cfg_we = 1'b0;
        check("cfg_err_int1", {63'd0, cfg_err}, 64'd1);
        step();
        check("cfg_err_one_cycle", {63'd0, cfg_err}, 64'd0);
        wait_until(e0 + 80);
        cfg_int = 16'd0; cfg_we = 1'b1; step(); cfg_we = 1'b0;
        check("cfg_err_int0", {63'd0, cfg_err}, 64'd1);
        drain(400);
        baud_en = 1'b0;

        // Resync from stop, then resync exactly on a period end at ph=5.
        step();
        resync = 1'b1; baud_en = 1'b1; last_ref = cyc + 1;
        for (int i = 1; i <= 5; i++) push(10, i);
        step(); resync = 1'b0;
        drain(200);
        wait_until(last_ref + 9);
        resync = 1'b1; last_ref = cyc + 1;
        for (int i = 1; i <= 16; i++) push(10, i);
        step(); resync = 1'b0;
        check("resync_suppress", {61'd0, os_tick, bit_tick, mid_tick}, 64'd0);
        drain(300);

        // Pending shadow applied immediately by resync.
        cfg_int = 16'd6; cfg_frac = 4'd0; cfg_we = 1'b1; step(); cfg_we = 1'b0;
        resync = 1'b1; last_ref = cyc + 1;
        for (int i = 1; i <= 3; i++) push(6, i);
        step(); resync = 1'b0;
        drain(100);
        baud_en = 1'b0;

        // Freeze for 100 cycles mid-period; period resumes with remaining count.
        step();
        resync = 1'b1; baud_en = 1'b1; r = cyc + 1; last_ref = r;
        push(106, 1); push(6, 2); push(6, 3);
        step(); resync = 1'b0;
        wait_until(r + 2);
        baud_en = 1'b0;
        quiet = 0;
        repeat (100) begin
            step();
            quiet += int'(os_tick | bit_tick | mid_tick);
        end
        check("stall_quiet", 64'(quiet), 64'd0);
        baud_en = 1'b1;
        drain(200);

        // Reset on the edge a tick was due: no tick, default divisor back.
        wait_until(last_ref + 5);
        rst = 1'b1; step();
        check("rst_abort_tick", {60'd0, os_tick, bit_tick, mid_tick, cfg_err}, 64'd0);
        step(); step();
        check("rst_hold_quiet", {60'd0, os_tick, bit_tick, mid_tick, cfg_err}, 64'd0);
        rst = 1'b0; last_ref = cyc;
`ifdef UART_BAUD_FRAC_EN
        push(325, 1); push(325, 2); push(326, 3);
`else
        push(325, 1); push(325, 2); push(325, 3);
`endif
        drain(1200);
        baud_en = 1'b0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Programmable fractional-N baud generator for the UART TX/RX datapaths. Divides `clk` into an oversample tick, a bit tick and a mid-bit sample tick. The divisor is runtime-loadable with glitch-free switching at period boundaries. A resync input re-phases the generator to a detected start-bit edge for the receiver. Successor to the fixed-divisor TX tick generator: adds fractional division, oversampling, phase outputs and runtime configuration.

## Interface
- `SYS_CLK`, 50000000, input clock frequency in Hz.
- `BAUD`, 9600, reset-default baud rate.
- `OVS`, 16, oversample ticks per bit; even, ≥4.
- `DIV_W`, 16, integer divisor width.
- `FRAC_W`, 4, fractional divisor width.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `baud_en`  in  1  run enable; low freezes all counters.
- `cfg_we`  in  1  single-cycle divisor write strobe.
- `cfg_int`  in  DIV_W  integer divisor, in clocks per oversample tick.
- `cfg_frac`  in  FRAC_W  fractional divisor, in 1/2^FRAC_W clock units.
- `resync`  in  1  restart bit phase; one-cycle pulse.
- `os_tick`  out  1  oversample tick, one-cycle pulse.
- `bit_tick`  out  1  end-of-bit pulse; coincides with an `os_tick`.
- `mid_tick`  out  1  mid-bit sample pulse; coincides with an `os_tick`.
- `cfg_err`  out  1  one-cycle pulse on a rejected `cfg_we`.

## Operation
- Reset-default divisor:
  - `DEF_INT = SYS_CLK/(BAUD*OVS)` (integer division).
  - `DEF_FRAC = (SYS_CLK*2^FRAC_W/(BAUD*OVS)) mod 2^FRAC_W`.
  - Defaults give 325 and 8, i.e. 325.5.
- Active divisor registers `div_int`/`div_frac`, shadow registers `sh_int`/`sh_frac`, and a `sh_pend` flag.
- Clock counter `cnt`, DIV_W+1 bits:
  - Counts 0..P-1, where P = `div_int` + `carry`.
  - `carry` is latched from the fractional accumulator `acc` (FRAC_W bits).
- At `cnt == P-1` with `baud_en` high:
  - `os_tick` pulses and `cnt` returns to 0.
  - {`carry`,`acc`} <= `acc + div_frac`, with the sum taken FRAC_W+1 bits wide.
  - If `sh_pend` is set, shadow is copied to active and `sh_pend` clears. The new divisor governs the next period.
- Phase counter `ph`, 0..OVS-1, increments on each `os_tick` and wraps to 0.
  - `bit_tick` = `os_tick` AND `ph == OVS-1`.
  - `mid_tick` = `os_tick` AND `ph == OVS/2-1`.
- `cfg_we`:
  - `cfg_int < 2`: write rejected, `cfg_err` pulses, active and shadow unchanged.
  - Otherwise, `baud_en` low: active divisor loads directly.
  - Otherwise, `baud_en` high: shadow loads and `sh_pend` sets. A second write before the boundary overwrites the shadow.
- `resync`, regardless of `baud_en`:
  - Clears `cnt`, `acc`, `carry` and `ph`.
  - Suppresses every tick in that cycle.
  - Applies a pending shadow immediately.
  - Has priority over a coincident period end.
- `baud_en` low: `cnt`, `acc` and `ph` hold, and all ticks are 0. Counting resumes from the held values.
- `rst`:
  - Loads the default divisor into active and shadow, clears `sh_pend`, `cnt`, `acc`, `carry` and `ph`.
  - All outputs read 0.
  - Reset mid-operation aborts the current period with no partial tick.

## Timing
- All outputs are registered, with reset value 0.
- Each tick is high for exactly one `clk` cycle.
- Latency from `rst` low or `resync`, with `baud_en` held high: the first `os_tick` is high in the `div_int`-th cycle after the edge that cleared the counters.
- Period length:
  - `os_tick` spacing is `div_int` or `div_int+1` clocks.
  - Over 2^FRAC_W oversample ticks, exactly `div_frac` periods are `div_int+1` clocks long.
- `bit_tick` spacing averages OVS×(`div_int` + `div_frac`/2^FRAC_W) clocks.
- After `resync`, the first `mid_tick` comes on the (OVS/2)-th `os_tick`, and the first `bit_tick` comes on the OVS-th.
- `cfg_err` is high in the cycle after the rejected `cfg_we`.
- A shadow copy takes effect at the first period boundary after the write, with no short or merged period.

## Configuration
- Macro `UART_BAUD_FRAC_EN`.
- Defined: fractional accumulator present, behaving as above.
- Undefined:
  - `acc` and `carry` are removed, and `cfg_frac` and `DEF_FRAC` are ignored.
  - P = `div_int` always.
  - All other behaviour is identical.

## Test plan
- Default reset, `baud_en` high for 40 000 cycles, with `UART_BAUD_FRAC_EN` defined:
  - `os_tick` spacing alternates 325/326.
  - `bit_tick` spacing is 5208 clocks ±1.
  - `mid_tick` comes exactly 8 `os_tick`s after each `bit_tick`.
- Write `cfg_int=4`, `cfg_frac=8` with `baud_en` low, then enable: `os_tick` spacing is 4,5,4,5…, i.e. 9 clocks per 2 ticks.
- While running at int 4, write `cfg_int=10`, `cfg_frac=0` mid-period:
  - The current period completes at its old length.
  - Every later period is 10.
  - There is no tick glitch.
- Write `cfg_int=1`: `cfg_err` pulses once and `os_tick` spacing is unchanged.
- Pulse `resync` at `ph=5`:
  - No tick in that cycle.
  - The next `mid_tick` comes 8×P clocks later.
  - `bit_tick` comes 16×P clocks later.
- Drop `baud_en` for 100 cycles mid-period: no ticks, and the period resumes with its remaining count. Then assert `rst` mid-period: outputs are 0 and the default divisor is restored.
